multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 59 +++++
 rtl/multicycle_ctrl.sv | 161 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller and the ALU control block.
// Contents:
//   state_t     - controller state codes. The numeric codes appear on the debug port.
//   OP_*        - primary opcodes, taken from instr[31:26].
//   ALUOP_*     - ALUOp encoding driven to the ALU control block.
//   SRCB_*      - ALU operand B select.
//   PCSRC_*     - PC source select.
//   decode_target() - the state that DECODE moves to for a given opcode.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_ILL    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b010000;
  localparam logic [5:0] OP_ADDI  = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b100000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic state_t decode_target(input logic [5:0] op);
    case (op)
      OP_RTYPE:     return S_REXEC;
      OP_LW, OP_SW: return S_MEMADR;
      OP_ADDI:      return S_IEXEC;
      OP_BEQ:       return S_BRANCH;
      OP_J:         return S_JUMP;
      default:      return S_ILL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle datapath controller.
//
// state  | meaning
// FETCH  | read instruction; IR and PC+4 written on the exit cycle
// DECODE | branch target into ALUOut, dispatch on opcode
// MEMADR | compute base + imm for lw/sw
// MEMRD  | data read, waits on mem_ready
// MEMWB  | load data into rt
// MEMWR  | data write, waits on mem_ready
// REXEC  | R-type ALU operation
// RWB    | ALU result into rd
// IEXEC  | addi ALU operation
// IWB    | ALU result into rt
// BRANCH | conditional PC write with ALUOut target
// JUMP   | PC <- jump target
// ILL    | one-cycle illegal-opcode pulse
//
// Ports:
//   clk, reset      - single clock, synchronous active-high reset
//   opcode          - instr[31:26] from the instruction register
//   mem_ready       - memory access completes this cycle
//   PCWrite .. ALUSrcA, ALUSrcB, PCSource, ALUOp - datapath strobes/selects
//   state           - current state code (debug)
//   illegal         - one-cycle pulse for an undecoded opcode
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       RegDest,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [3:0] state,
  output logic       illegal
);

  state_t state_q;
  state_t state_d;
  logic   mem_done;

  assign mem_done = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign state    = state_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_done ? S_DECODE : S_FETCH;
      S_DECODE: state_d = decode_target(opcode);
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:  state_d = mem_done ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_done ? S_FETCH : S_MEMWR;
      S_REXEC:  state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Decoded from the registered state. Two qualifiers are deliberate:
  // IR/PC writes in FETCH fire only on the cycle the read completes so a
  // stalled fetch updates them once, and reset masks every write strobe
  // because the register still holds the pre-reset state for that cycle.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegWrite    = 1'b0;
    RegDest     = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    PCSource    = PCSRC_ALU;
    ALUOp       = ALUOP_ADD;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_done;
        PCWrite = mem_done;
      end
      S_DECODE: ALUSrcB = SRCB_IMM_SH;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_REXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDest  = 1'b1;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_IMM;
      end
      S_IWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      S_ILL:   illegal = 1'b1;
      default: ;
    endcase
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      MemWrite    = 1'b0;
      illegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemToReg, RegWrite, RegDest, ALUSrcA, illegal;
  logic [1:0] ALUSrcB, PCSource, ALUOp;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;

  multicycle_ctrl #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .RegDest(RegDest),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [16:0] obs_out;
  logic [5:0]  obs_wr;
  assign obs_out = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                    MemToReg, RegWrite, RegDest, ALUSrcA, ALUSrcB, PCSource,
                    ALUOp, illegal};
  assign obs_wr  = {PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite, illegal};

  // Output table written straight from the per-state behaviour description.
  function automatic logic [16:0] exp_out(input int st, input bit fetch_exit);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rw, rd, asa, ill;
    logic [1:0] srcb, pcs, aop;
    {pcw, pcwc, iord, mr, mw, irw, m2r, rw, rd, asa, ill} = '0;
    srcb = 2'b00; pcs = 2'b00; aop = 2'b00;
    case (st)
      0:  begin mr = 1; srcb = 2'b01; irw = fetch_exit; pcw = fetch_exit; end
      1:  srcb = 2'b11;
      2:  begin asa = 1; srcb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; srcb = 2'b10; aop = 2'b11; end
      9:  rw = 1;
      10: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      11: begin pcw = 1; pcs = 2'b10; end
      12: ill = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rw, rd, asa, srcb, pcs, aop, ill};
  endfunction

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  typedef struct { int st; bit rdy; } step_t;
  step_t q[$];

  task automatic push_one(input int st);
    step_t s;
    s.st = st; s.rdy = 1'($urandom_range(0, 1));
    q.push_back(s);
  endtask

  task automatic push_wait(input int st, input int waits);
    step_t s;
    s.st = st;
    for (int k = 0; k < waits; k++) begin
      s.rdy = 1'b0;
      q.push_back(s);
    end
    s.rdy = 1'b1;
    q.push_back(s);
  endtask

  // Expected trace of one instruction: state visited each cycle and the
  // mem_ready value the bench drives that cycle.
  task automatic build(input logic [5:0] op, input int fw, input int mw);
    q.delete();
    push_wait(0, fw);
    push_one(1);
    case (op)
      6'b000000: begin push_one(6); push_one(7); end
      6'b001000: begin push_one(2); push_wait(3, mw); push_one(4); end
      6'b010000: begin push_one(2); push_wait(5, mw); end
      6'b000010: begin push_one(8); push_one(9); end
      6'b000100: push_one(10);
      6'b100000: push_one(11);
      default:   push_one(12);
    endcase
  endtask

  task automatic run(input logic [5:0] op, input int fw, input int mw);
    build(op, fw, mw);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      opcode    = op;
      mem_ready = q[i].rdy;
      #1;
      chk($sformatf("state op=%b cyc=%0d", op, i), 17'(state), 17'(q[i].st));
      chk($sformatf("outputs op=%b st=%0d cyc=%0d", op, q[i].st, i), obs_out,
          exp_out(q[i].st, (q[i].st == 0) && q[i].rdy));
      chk($sformatf("rd_wr_excl op=%b cyc=%0d", op, i), 17'(MemRead & MemWrite), 17'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [5:0] ops[6];

  initial begin
    ops[0] = 6'b000000; ops[1] = 6'b001000; ops[2] = 6'b010000;
    ops[3] = 6'b000010; ops[4] = 6'b000100; ops[5] = 6'b100000;
    reset = 1'b1; opcode = 6'b0; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_state", 17'(state), 17'd0);
    chk("reset_strobes", 17'(obs_wr), 17'd0);
    reset = 1'b0; mem_ready = 1'b0;

    // lw no waits, sw with 3 write waits, beq, j, illegal, R then addi
    run(6'b001000, 0, 0);
    run(6'b010000, 0, 3);
    run(6'b000100, 0, 0);
    run(6'b100000, 0, 0);
    run(6'b111111, 0, 0);
    run(6'b000000, 0, 0);
    run(6'b000010, 0, 0);
    run(6'b001000, 2, 2);

    // Reset during a MEMRD wait
    @(negedge clk); opcode = 6'b001000; mem_ready = 1'b1; #1;
    chk("rst_seq_fetch", 17'(state), 17'd0);
    @(negedge clk); #1; chk("rst_seq_decode", 17'(state), 17'd1);
    @(negedge clk); #1; chk("rst_seq_memadr", 17'(state), 17'd2);
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("rst_seq_memrd", 17'(state), 17'd3);
    @(negedge clk); reset = 1'b1; #1;
    chk("rst_memrd_hold", 17'(state), 17'd3);
    chk("rst_memrd_strobes", 17'(obs_wr), 17'd0);
    @(negedge clk); mem_ready = 1'b1; #1;
    chk("rst_to_fetch", 17'(state), 17'd0);
    chk("rst_fetch_strobes", 17'(obs_wr), 17'd0);
    @(negedge clk); reset = 1'b0; mem_ready = 1'b0; #1;
    chk("post_rst_state", 17'(state), 17'd0);
    chk("post_rst_outputs", obs_out, exp_out(0, 1'b0));
    run(6'b100000, 0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 6) == 0) op = 6'($urandom_range(0, 63));
      else                           op = ops[$urandom_range(0, 5)];
      run(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    @(negedge clk); #1;
    chk("final_fetch", 17'(state), 17'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
